// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory slave.
//   state_e    : transfer FSM states
//   WAIT_*     : wait-state source selection for WAIT_MODE
//   LFSR_TAPS  : feedback taps of the 8-bit wait LFSR, x^8+x^6+x^5+x^4+1
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int WAIT_NONE  = 0;
  localparam int WAIT_FIXED = 1;
  localparam int WAIT_RAND  = 2;

  // Bit i set means lfsr[i] feeds the XOR; bits 7,5,4,3 give x^8+x^6+x^5+x^4+1.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/apb_wait_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used as the pseudo-random wait source.
// Shifts left every clock regardless of bus traffic; a nonzero seed keeps it
// out of the all-zero lock-up state.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, loads LFSR_SEED
//   lfsr_o   : current LFSR value
module apb_wait_lfsr
  import apb_mem_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/apb_mem_slave_p.sv
// Parametrised APB slave backed by a register-array memory, with byte
// strobes, selectable wait states, PSLVERR on out-of-range word index and
// clean abort when PSEL drops mid-transfer.
//   clk, reset_n          : clock (rising edge), async active-low reset
//   psel_i, penable_i     : APB select / access-phase enable
//   paddr_i, pwrite_i     : byte address, 1 = write
//   pwdata_i, pstrb_i     : write data, byte write strobes
//   prdata_o              : read data, nonzero only on a completing good read
//   pready_o, pslverr_o   : transfer complete, error response
//
// state  | meaning
// IDLE   | no transfer in progress; a direct access (no setup) is accepted here
// SETUP  | setup phase (psel & ~penable seen while IDLE); decoded from the bus
//        | in the same cycle so the first access cycle is already ACCESS
// ACCESS | access phase; cnt counts down wait cycles, pready when it hits 0
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int         ADDR_W     = 12,
  parameter int         DATA_W     = 32,
  parameter int         DEPTH      = 64,
  parameter int         WAIT_MODE  = 2,
  parameter int         FIXED_WAIT = 2,
  parameter int         RAND_W     = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o,
  output logic                pslverr_o
);

  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MIDX_W = $clog2(DEPTH);
  localparam int CNT_W  = 4;
  localparam logic [IDX_W:0] DEPTH_L   = (IDX_W + 1)'(DEPTH);
  localparam logic [7:0]     RAND_MASK = 8'((1 << RAND_W) - 1);

  state_e             state_q, state_d, phase;
  logic [CNT_W-1:0]   cnt_q, cnt_d, wait_val;
  logic [7:0]         lfsr;
  logic [IDX_W-1:0]   idx;
  logic [MIDX_W-1:0]  mem_idx;
  logic               err, wr_en;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];

  apb_wait_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .lfsr_o (lfsr)
  );

  // Byte-offset bits drop out of the shift; the full word index is kept so
  // that out-of-range addresses can be flagged before truncating to mem_idx.
  assign idx     = IDX_W'(paddr_i >> OFF_W);
  assign mem_idx = MIDX_W'(idx);
  assign err     = {1'b0, idx} >= DEPTH_L;

  always_comb begin
    wait_val = '0;
    case (WAIT_MODE)
      WAIT_FIXED: wait_val = CNT_W'(FIXED_WAIT);
      WAIT_RAND:  wait_val = CNT_W'(lfsr & RAND_MASK);
      default:    wait_val = '0;
    endcase
  end

  // A setup cycle is recognised combinationally so that a zero-wait access
  // completes in the first penable cycle (standard two-cycle APB transfer).
  always_comb begin
    phase = state_q;
    if (state_q == IDLE && psel_i && !penable_i) phase = SETUP;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (phase)
      IDLE: begin
        // Only reachable with psel high if penable is high: direct access.
        if (psel_i) begin
          cnt_d   = wait_val;
          state_d = ACCESS;
        end
      end
      SETUP: begin
        cnt_d   = wait_val;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel_i || !penable_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pready_o  = (phase == ACCESS) && psel_i && penable_i && (cnt_q == '0);
    pslverr_o = pready_o && err;
    wr_en     = pready_o && pwrite_i && !err;
    prdata_o  = '0;
    if (pready_o && !pwrite_i && !err) prdata_o = mem_q[mem_idx];
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (pstrb_i[b]) mem_d[mem_idx][8*b +: 8] = pwdata_i[8*b +: 8];
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
module tb_apb_mem_slave_p;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_v [3];
  logic        pready_v [3];
  logic        pslverr_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word storage per DUT plus the spec'd LFSR sequence.
  logic [31:0] mdl [3][64];
  bit          vld [3][64];
  logic [7:0]  m_lfsr;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  apb_mem_slave_p #(.ADDR_W(12), .DATA_W(32), .DEPTH(64), .WAIT_MODE(0), .FIXED_WAIT(2),
                    .RAND_W(3), .LFSR_SEED(8'hA5)) u0 (
    .clk(clk), .reset_n(reset_n), .psel_i(psel[0]), .penable_i(penable), .paddr_i(paddr),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_v[0]),
    .pready_o(pready_v[0]), .pslverr_o(pslverr_v[0]));

  apb_mem_slave_p #(.ADDR_W(12), .DATA_W(32), .DEPTH(64), .WAIT_MODE(1), .FIXED_WAIT(3),
                    .RAND_W(3), .LFSR_SEED(8'hA5)) u1 (
    .clk(clk), .reset_n(reset_n), .psel_i(psel[1]), .penable_i(penable), .paddr_i(paddr),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_v[1]),
    .pready_o(pready_v[1]), .pslverr_o(pslverr_v[1]));

  apb_mem_slave_p #(.ADDR_W(12), .DATA_W(32), .DEPTH(64), .WAIT_MODE(2), .FIXED_WAIT(2),
                    .RAND_W(3), .LFSR_SEED(8'hA5)) u2 (
    .clk(clk), .reset_n(reset_n), .psel_i(psel[2]), .penable_i(penable), .paddr_i(paddr),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_v[2]),
    .pready_o(pready_v[2]), .pslverr_o(pslverr_v[2]));

  function automatic int exp_wait(input int d, input logic [7:0] lf);
    if (d == 0) return 0;
    if (d == 1) return 3;
    return int'(lf[2:0]);
  endfunction

  // One APB transfer (setup + access until pready), starting just after a
  // rising edge and ending just after the completing edge. Returns the
  // model LFSR value seen during the setup cycle.
  task automatic xfer(input int d, input logic [11:0] a, input bit w, input logic [31:0] wd,
                      input logic [3:0] sb, output logic [31:0] rd, output bit err,
                      output int lat, output logic [7:0] lf);
    bit done;
    int i;
    lf = m_lfsr;
    psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; pstrb = sb;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; done = 0; rd = '0; err = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pready_v[d]) begin
        rd = prdata_v[d]; err = pslverr_v[d]; done = 1;
      end else begin
        lat++;
      end
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL xfer_timeout dut%0d addr=%h: no pready in 40 cycles, required within 16", d, a);
    end else if (w && (a >> 2) < 64) begin
      i = int'(a >> 2);
      for (int b = 0; b < 4; b++) if (sb[b]) mdl[d][i][8*b +: 8] = wd[8*b +: 8];
      if (sb == 4'hF) vld[d][i] = 1;
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0 || prdata_v[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: pready=%b pslverr=%b prdata=%h, required 0/0/0",
                 d, pready_v[d], pslverr_v[d], prdata_v[d]);
      end
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; bit err; int lat; logic [7:0] lf;
    xfer(0, 12'h010, 1, 32'hDEADBEEF, 4'hF, rd, err, lat, lf);
    n_tests++;
    if (lat !== 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL zw_write: lat=%0d err=%b, required 0/0", lat, err);
    end
    xfer(0, 12'h010, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (lat !== 0 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL zw_read: lat=%0d err=%b rd=%h, required 0/0/deadbeef", lat, err, rd);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; bit err; int lat; logic [7:0] lf;
    xfer(0, 12'h020, 1, 32'h11223344, 4'hF, rd, err, lat, lf);
    xfer(0, 12'h022, 1, 32'hAABBCCDD, 4'b0101, rd, err, lat, lf);
    xfer(0, 12'h021, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (rd !== 32'h11BB33DD || err !== 1'b0) begin
      n_fail++; $display("FAIL strobe_merge: rd=%h err=%b, required 11bb33dd/0", rd, err);
    end
  endtask

  task automatic test_fixed_wait();
    logic [31:0] rd; bit err; int lat; logic [7:0] lf;
    xfer(1, 12'h030, 1, 32'h5A5A0F0F, 4'hF, rd, err, lat, lf);
    n_tests++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL fixed_write_lat: lat=%0d, required 3", lat);
    end
    for (int t = 0; t < 10; t++) begin
      xfer(1, 12'h030, 0, 32'h0, 4'h0, rd, err, lat, lf);
      n_tests++;
      if (lat !== 3 || rd !== 32'h5A5A0F0F || err !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_read_%0d: lat=%0d rd=%h err=%b, required 3/5a5a0f0f/0", t, lat, rd, err);
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; bit err; int lat; logic [7:0] lf;
    xfer(0, 12'h000, 1, 32'hCAFEF00D, 4'hF, rd, err, lat, lf);
    xfer(0, 12'h100, 1, 32'h99999999, 4'hF, rd, err, lat, lf);
    n_tests++;
    if (lat !== 0 || err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL err_write: lat=%0d err=%b rd=%h, required 0/1/0", lat, err, rd);
    end
    xfer(0, 12'hFFC, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL err_read_top: err=%b rd=%h, required 1/0", err, rd);
    end
    xfer(0, 12'h0FC, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL last_word_ok: err=%b, required 0", err);
    end
    xfer(0, 12'h000, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (rd !== 32'hCAFEF00D || err !== 1'b0) begin
      n_fail++; $display("FAIL err_no_alias: rd=%h err=%b, required cafef00d/0", rd, err);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, e_rd; bit err, w, e_err, chk; int lat, ew, i, ndist;
    logic [7:0] lf; logic [11:0] a; logic [3:0] sb; bit seen [8];
    for (int k = 0; k < 8; k++) seen[k] = 0;
    for (int k = 0; k < 8; k++) begin
      xfer(2, 12'(k * 4), 1, $urandom, 4'hF, rd, err, lat, lf);
      n_tests++;
      if (lat !== exp_wait(2, lf)) begin
        n_fail++; $display("FAIL rand_preload_lat_%0d: lat=%0d, required %0d", k, lat, exp_wait(2, lf));
      end
    end
    for (int t = 0; t < 50; t++) begin
      if ($urandom_range(0, 7) == 0) a = 12'(12'h100 + $urandom_range(0, 12'hEFF));
      else                           a = 12'($urandom_range(0, 12'h01F));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      sb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      i = int'(a >> 2);
      e_err = (i >= 64);
      chk = w || e_err || vld[2][i % 64];
      e_rd = (!w && !e_err) ? mdl[2][i % 64] : 32'h0;
      xfer(2, a, w, wd, sb, rd, err, lat, lf);
      ew = exp_wait(2, lf);
      if (lat >= 0 && lat < 8) seen[lat] = 1;
      n_tests++;
      if (lat !== ew || lat > 7 || err !== e_err || (chk && rd !== e_rd)) begin
        n_fail++;
        $display("FAIL rand_xfer_%0d addr=%h w=%b: lat=%0d err=%b rd=%h, required %0d/%b/%h",
                 t, a, w, lat, err, rd, ew, e_err, e_rd);
      end
    end
    ndist = 0;
    for (int k = 0; k < 8; k++) if (seen[k]) ndist++;
    n_tests++;
    if (ndist < 4) begin
      n_fail++; $display("FAIL rand_distinct: %0d distinct latencies, required >= 4", ndist);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; bit err; int lat; logic [7:0] lf;
    xfer(1, 12'h004, 1, 32'h0BADCAFE, 4'hF, rd, err, lat, lf);
    psel[1] = 1'b1; penable = 1'b0; paddr = 12'h004; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk);
    n_tests++;
    if (pready_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait1: pready=%b, required 0", pready_v[1]);
    end
    @(posedge clk); #1; psel[1] = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_tests++;
    if (pready_v[1] !== 1'b0 || pslverr_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL abort_drop: pready=%b pslverr=%b, required 0/0", pready_v[1], pslverr_v[1]);
    end
    @(posedge clk); #1;
    n_tests++;
    if (u1.state_q !== apb_mem_pkg::IDLE) begin
      n_fail++; $display("FAIL abort_idle: state=%0d, required %0d", u1.state_q, apb_mem_pkg::IDLE);
    end
    xfer(1, 12'h004, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (rd !== 32'h0BADCAFE || lat !== 3 || err !== 1'b0) begin
      n_fail++; $display("FAIL abort_nowrite: rd=%h lat=%0d err=%b, required 0badcafe/3/0", rd, lat, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; bit err; int lat; logic [7:0] lf;
    xfer(0, 12'h008, 1, 32'h01234567, 4'hF, rd, err, lat, lf);
    psel[0] = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b1;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1'b1;
    #2;
    n_tests++;
    if (pready_v[0] !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_ready: pready=%b, required 1", pready_v[0]);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (pready_v[0] !== 1'b0 || pslverr_v[0] !== 1'b0 || prdata_v[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: pready=%b pslverr=%b prdata=%h, required 0/0/0",
               pready_v[0], pslverr_v[0], prdata_v[0]);
    end
    psel[0] = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 12'h008, 0, 32'h0, 4'h0, rd, err, lat, lf);
    n_tests++;
    if (rd !== 32'h01234567 || lat !== 0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_write: rd=%h lat=%0d err=%b, required 01234567/0/0", rd, lat, err);
    end
    for (int t = 0; t < 4; t++) begin
      xfer(2, 12'(t * 4), 0, 32'h0, 4'h0, rd, err, lat, lf);
      n_tests++;
      if (lat !== exp_wait(2, lf) || rd !== mdl[2][t]) begin
        n_fail++;
        $display("FAIL rst_rand_%0d: lat=%0d rd=%h, required %0d/%h", t, lat, rd, exp_wait(2, lf), mdl[2][t]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int d = 0; d < 3; d++) for (int k = 0; k < 64; k++) begin
      mdl[d][k] = '0; vld[d][k] = 0;
    end
    #1;
    test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    test_zero_wait();
    test_strobe();
    test_fixed_wait();
    test_error();
    test_random();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
Parametrised APB slave with on-chip register-array memory. Next generation of the team's simple APB memory slave.
Adds configurable data/address width and depth, byte strobes, and selectable wait-state mode (none/fixed/pseudo-random). Also adds PSLVERR for out-of-range accesses and clean abort when PSEL drops mid-transfer.
Sits behind the APB master/arbiter as a peripheral target.

Parameters:
ADDR_W, 12, APB address width in bits.
DATA_W, 32, data width; must be 8, 16, 32 or 64.
DEPTH, 64, number of DATA_W words; 2 <= DEPTH <= 2**(ADDR_W-log2(DATA_W/8)).
WAIT_MODE, 2, 0 = zero wait, 1 = fixed FIXED_WAIT cycles, 2 = random from LFSR.
FIXED_WAIT, 2, wait cycles in mode 1 (0..15).
RAND_W, 3, random wait width in mode 2; wait is 0..2**RAND_W-1 (1..4).
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
psel_i  input  1  APB select.
penable_i  input  1  APB enable (access phase).
paddr_i  input  ADDR_W  byte address.
pwrite_i  input  1  1 = write, 0 = read.
pwdata_i  input  DATA_W  write data.
pstrb_i  input  DATA_W/8  byte write strobes.
prdata_o  output  DATA_W  read data.
pready_o  output  1  transfer complete.
pslverr_o  output  1  error response, valid only with pready_o.

Behaviour:
- Reset (reset_n low, async):
  - FSM to IDLE; wait counter 0; LFSR = LFSR_SEED.
  - pready_o, pslverr_o, prdata_o all 0.
  - Memory contents not reset; undefined until written.
- Word index idx = paddr_i[ADDR_W-1:log2(DATA_W/8)]. Low byte-offset bits ignored.
- Error condition: idx >= DEPTH.
- FSM states:
  - IDLE:
    - psel_i & ~penable_i (setup): load cnt from wait source; -> SETUP.
    - psel_i & penable_i without a setup: load cnt and -> ACCESS. Same wait as a setup-first transfer plus zero extra cycles.
  - SETUP: -> ACCESS next cycle, unconditionally.
  - ACCESS (psel_i & penable_i):
    - cnt != 0: pready_o = 0, cnt decrements.
    - cnt == 0: pready_o = 1 combinationally this cycle; -> IDLE on the next edge.
- Wait source:
  - Mode 0 gives 0.
  - Mode 1 gives FIXED_WAIT.
  - Mode 2 gives lfsr[RAND_W-1:0].
- Latency from start of access phase to pready_o high is exactly cnt cycles.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts left every cycle regardless of traffic. Never reaches 0.
- Write: committed at the clk edge where pready_o=1 & pwrite_i & ~error.
  - Byte lane b written only if pstrb_i[b]; other lanes retain old value.
- Read: prdata_o = mem[idx] when pready_o & ~pwrite_i & ~error; otherwise 0. Combinational from mem.
- Error: pslverr_o = pready_o & error.
  - No memory update.
  - prdata_o = 0.
  - Wait states still applied.
- Abort: psel_i low in SETUP or ACCESS -> IDLE next edge, no write, pready_o stays 0, cnt cleared.
- penable_i low while in ACCESS with psel_i high is a protocol violation. Treat as abort; a new setup follows.
- Back-to-back: a new setup may be sampled in the cycle after pready_o (IDLE); no dead cycle beyond APB minimum.
- pready_o and pslverr_o are 0 in IDLE and SETUP.
- Reset mid-transfer: transfer discarded, no write, outputs 0 immediately.

Decomposition:
- Package apb_mem_pkg holds:
  - State enum (IDLE, SETUP, ACCESS).
  - WAIT_MODE constants (WAIT_NONE=0, WAIT_FIXED=1, WAIT_RAND=2).
  - LFSR tap constant.
- Sub-module apb_wait_lfsr (clk, reset_n, LFSR_SEED param, 8-bit output) generates random waits.
- Memory array and FSM stay in top.

Test Plan:
- WAIT_MODE=0, DATA_W=32: write 0xDEADBEEF to 0x010 with pstrb 4'hF, then read 0x010. Expect pready_o in the first access cycle both times, prdata_o=0xDEADBEEF, pslverr_o=0.
- Partial strobe: preload 0x11223344 at 0x020, write 0xAABBCCDD with pstrb 4'b0101, read back. Expect 0x11BB33DD.
- WAIT_MODE=1, FIXED_WAIT=3: read any valid address. Expect pready_o low for 3 access cycles and high on the 4th; repeat 10 transfers with identical latency.
- DEPTH=64, DATA_W=32: write to 0x100 (idx 64). Expect pready_o=1 with pslverr_o=1, then read idx 0. Expect its contents unchanged and prdata_o=0 during the error cycle.
- WAIT_MODE=2, RAND_W=3, seed 8'hA5: 50 transfers. Check every latency is in 0..7 and matches the reference-model LFSR sequence; check at least 4 distinct latencies.
- Abort and reset:
  - Drop psel_i after 1 wait cycle of a write to 0x004. Expect no memory change and FSM in IDLE.
  - Assert reset_n low mid-access. Expect outputs 0 immediately and the next transfer behaves normally.
